memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
// MEM stage of the 5-stage MIPS pipeline; receiving end of the EX stage outputs. Holds the EX/MEM and
// MEM/WB pipeline registers and the byte-lane data memory (load/store byte, half, word).
// Returns forwarding values and destinations (EX/MEM, MEM/WB) to the forwarding unit and EX-stage muxes,
// and produces branch resolution (pcSrc) for IF.
// PARAMETERS
// N_BITS      32   datapath width
// N_BITS_REG  6    register-address field width (matches EX rt/rd outputs)
// MEM_DEPTH   256  data memory depth in 32-bit words (power of 2)
// PORTS
// i_clk         in   1           clock
// i_reset       in   1           reset i_reset, synchronous, active-high; clock i_clk
// i_enable      in   1           pipeline advance; 0 = stall (hold all regs, block writes)
// i_flush       in   1           insert bubble into EX/MEM (control bits cleared)
// i_aluResult   in   N_BITS      EX ALU result / effective address
// i_storeData   in   N_BITS      EX forwarded rt value (store data)
// i_cero        in   1           ALU zero flag
// i_rd          in   N_BITS_REG  destination register selected in EX
// i_memRead     in   1           load
// i_memWrite    in   1           store
// i_memToReg    in   1           WB selects load data
// i_regWrite    in   1           instruction writes register file
// i_branch      in   1           branch instruction
// i_size        in   2           00 byte, 01 half, 11 word, 10 reserved
// i_unsigned    in   1           zero-extend load (LBU/LHU)
// i_dbgAddr     in   log2(MEM_DEPTH)  debug word address
// o_memData         out N_BITS      EX/MEM ALU result (forward source 2'b10)
// o_rd_EX_MEM       out N_BITS_REG  EX/MEM destination
// o_regWrite_EX_MEM out 1           EX/MEM regWrite
// o_pcSrc           out 1           EX/MEM branch & cero
// o_branchTarget    out N_BITS      EX/MEM aluResult, valid when o_pcSrc
// o_wbData          out N_BITS      MEM/WB write-back value (forward source 2'b01)
// o_rd_MEM_WB       out N_BITS_REG  MEM/WB destination
// o_regWrite_MEM_WB out 1           MEM/WB regWrite (suppressed on fault)
// o_misaligned      out 1           MEM/WB fault flag, one cycle per faulting instruction
// o_dbgData         out N_BITS      memory word at i_dbgAddr, registered
// BEHAVIOUR
// - Reset: every output and all pipeline regs 0; memory array NOT cleared (sim-init to 0).
// - Cycle n inputs -> EX/MEM at edge n+1 -> MEM/WB at edge n+2 (latency 2 to o_wbData).
// - EX/MEM update when i_enable: i_flush=1 loads 0 into memRead/memWrite/regWrite/branch/memToReg,
//   data fields still captured. i_flush has priority over i_enable=0 (flush applies even when stalled).
// - Memory index = aluResult[log2(MEM_DEPTH)+1:2]; upper bits ignored (wrap modulo depth).
// - Misaligned = (half & addr[0]) | (word & addr[1:0]!=0) | size==10. On fault: no write,
//   load data 0, regWrite_MEM_WB forced 0, o_misaligned=1 for that instruction.
// - Store: at edge when EX/MEM memWrite & i_enable & !fault; byte enables from size/addr[1:0],
//   data replicated to lanes (byte to all 4, half to both halves).
// - Load: read combinational from EX/MEM address, lane selected by addr[1:0], sign/zero extended,
//   captured into MEM/WB. Load in cycle after store to same word returns new data.
// - o_wbData = memToReg ? loadData : aluResult. o_pcSrc combinational from EX/MEM regs.
// - i_enable=0: both pipeline reg sets hold, no memory write, o_dbgData still updates.
// - i_dbgAddr read port: o_dbgData registered every clock, independent of stall.
// STRUCTURE
// - mips_pkg: size codes (SZ_BYTE/SZ_HALF/SZ_WORD), forward-select codes, widths.
// - Sub-module data_memory: byte-enable RAM, 1 write port + 2 async read ports (pipe, debug).
// - Top holds EX/MEM, MEM/WB regs, lane align/extend, fault logic.
// TESTING
// - SW 0x11223344 @0x10, then LW @0x10 -> o_wbData=0x11223344 two edges after LW, regWrite=1.
// - SB 0x000000AB @0x13, LB @0x13 -> 0xFFFFFFAB; LBU -> 0x000000AB; LW @0x10 -> 0xAB223344.
// - LH @0x11 -> o_misaligned=1, o_regWrite_MEM_WB=0, memory unchanged; SW @0x12 -> no write.
// - i_branch=1,i_cero=1,aluResult=0x40 -> o_pcSrc=1, o_branchTarget=0x40 one edge later;
//   same with i_flush=1 -> o_pcSrc=0.
// - Stall: i_enable=0 for 3 cycles mid-SW -> outputs held, write only after enable returns.
// - Reset asserted mid-stream -> all outputs 0 next edge; LW afterwards still reads stored data.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: access-size codes, forwarding-select codes,
// default widths and the alignment rule used by the MEM stage.
package mips_pkg;

  localparam int N_BITS_DEF     = 32;
  localparam int N_BITS_REG_DEF = 6;
  localparam int MEM_DEPTH_DEF  = 256;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_RSVD = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  // Forwarding-unit mux selects for the EX-stage operand muxes
  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr);
    logic bad;
    case (size)
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-enable data RAM: one synchronous write port, asynchronous pipeline and debug read ports.
// Contents are not reset; only the pipeline around it is.
module data_memory #(
  parameter int N_BITS    = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic                         i_clk,
  input  logic                         i_we,
  input  logic [N_BITS/8-1:0]          i_be,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_addr,
  input  logic [N_BITS-1:0]            i_wdata,
  output logic [N_BITS-1:0]            o_rdata,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_dbgAddr,
  output logic [N_BITS-1:0]            o_dbgData
);

  logic [N_BITS-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < N_BITS/8; b++) begin
        if (i_be[b]) mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata   = mem_q[i_addr];
  assign o_dbgData = mem_q[i_dbgAddr];

endmodule

// File: rtl/memory_stage.sv
// MEM stage: EX/MEM and MEM/WB pipeline registers, byte-lane store/load alignment,
// misalignment fault handling, branch resolution and a registered debug read port.
module memory_stage
  import mips_pkg::*;
#(
  parameter int N_BITS     = N_BITS_DEF,
  parameter int N_BITS_REG = N_BITS_REG_DEF,
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic                         i_flush,
  input  logic [N_BITS-1:0]            i_aluResult,
  input  logic [N_BITS-1:0]            i_storeData,
  input  logic                         i_cero,
  input  logic [N_BITS_REG-1:0]        i_rd,
  input  logic                         i_memRead,
  input  logic                         i_memWrite,
  input  logic                         i_memToReg,
  input  logic                         i_regWrite,
  input  logic                         i_branch,
  input  logic [1:0]                   i_size,
  input  logic                         i_unsigned,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_dbgAddr,
  output logic [N_BITS-1:0]            o_memData,
  output logic [N_BITS_REG-1:0]        o_rd_EX_MEM,
  output logic                         o_regWrite_EX_MEM,
  output logic                         o_pcSrc,
  output logic [N_BITS-1:0]            o_branchTarget,
  output logic [N_BITS-1:0]            o_wbData,
  output logic [N_BITS_REG-1:0]        o_rd_MEM_WB,
  output logic                         o_regWrite_MEM_WB,
  output logic                         o_misaligned,
  output logic [N_BITS-1:0]            o_dbgData
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [N_BITS-1:0]     alu_q, store_q;
  logic [N_BITS_REG-1:0] rd_q;
  logic                  cero_q, mem_read_q, mem_write_q, mem_to_reg_q, reg_write_q, branch_q, uns_q;
  size_e                 size_q;

  logic [N_BITS-1:0]     wb_data_q, wb_data_d;
  logic [N_BITS_REG-1:0] wb_rd_q;
  logic                  wb_reg_write_q, wb_reg_write_d, wb_mis_q, wb_mis_d;
  logic [N_BITS-1:0]     dbg_q, dbg_rdata;

  logic [N_BITS-1:0]     rd_word, rd_shift, load_ext, load_data, wr_data;
  logic [N_BITS/8-1:0]   wr_be;
  logic [1:0]            lane;
  logic                  fault, mem_we;

  // A flush still captures the data fields so the bubble carries a defined address/rd
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      alu_q        <= '0;
      store_q      <= '0;
      rd_q         <= '0;
      cero_q       <= 1'b0;
      size_q       <= SZ_BYTE;
      uns_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      branch_q     <= 1'b0;
    end else if (i_enable || i_flush) begin
      alu_q        <= i_aluResult;
      store_q      <= i_storeData;
      rd_q         <= i_rd;
      cero_q       <= i_cero;
      size_q       <= size_e'(i_size);
      uns_q        <= i_unsigned;
      mem_read_q   <= i_memRead  & ~i_flush;
      mem_write_q  <= i_memWrite & ~i_flush;
      mem_to_reg_q <= i_memToReg & ~i_flush;
      reg_write_q  <= i_regWrite & ~i_flush;
      branch_q     <= i_branch   & ~i_flush;
    end
  end

  assign lane   = alu_q[1:0];
  assign fault  = (mem_read_q | mem_write_q) & is_misaligned(size_q, lane);
  assign mem_we = mem_write_q & i_enable & ~fault & ~i_reset;

  always_comb begin
    wr_data = store_q;
    wr_be   = '0;
    case (size_q)
      SZ_BYTE: begin
        wr_data = {4{store_q[7:0]}};
        wr_be   = 4'b0001 << lane;
      end
      SZ_HALF: begin
        wr_data = {2{store_q[15:0]}};
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  data_memory #(
    .N_BITS   (N_BITS),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_data_memory (
    .i_clk    (i_clk),
    .i_we     (mem_we),
    .i_be     (wr_be),
    .i_addr   (alu_q[AW+1:2]),
    .i_wdata  (wr_data),
    .o_rdata  (rd_word),
    .i_dbgAddr(i_dbgAddr),
    .o_dbgData(dbg_rdata)
  );

  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    load_ext = '0;
    case (size_q)
      SZ_BYTE: load_ext = {{(N_BITS-8){~uns_q & rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: load_ext = {{(N_BITS-16){~uns_q & rd_shift[15]}}, rd_shift[15:0]};
      SZ_WORD: load_ext = rd_word;
      default: load_ext = '0;
    endcase
  end

  assign load_data      = fault ? '0 : load_ext;
  assign wb_data_d      = mem_to_reg_q ? load_data : alu_q;
  assign wb_reg_write_d = reg_write_q & ~fault;
  assign wb_mis_d       = fault;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wb_data_q      <= '0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      wb_mis_q       <= 1'b0;
    end else if (i_enable) begin
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= rd_q;
      wb_reg_write_q <= wb_reg_write_d;
      wb_mis_q       <= wb_mis_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) dbg_q <= '0;
    else         dbg_q <= dbg_rdata;
  end

  assign o_memData         = alu_q;
  assign o_rd_EX_MEM       = rd_q;
  assign o_regWrite_EX_MEM = reg_write_q;
  assign o_pcSrc           = branch_q & cero_q;
  assign o_branchTarget    = alu_q;
  assign o_wbData          = wb_data_q;
  assign o_rd_MEM_WB       = wb_rd_q;
  assign o_regWrite_MEM_WB = wb_reg_write_q;
  assign o_misaligned      = wb_mis_q;
  assign o_dbgData         = dbg_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed MIPS load/store/branch/stall/reset steps followed by
// randomized traffic, checked against a byte-addressed reference model.
module tb_memory_stage;

  logic        i_clk, i_reset, i_enable, i_flush;
  logic [31:0] i_aluResult, i_storeData;
  logic        i_cero, i_memRead, i_memWrite, i_memToReg, i_regWrite, i_branch, i_unsigned;
  logic [5:0]  i_rd;
  logic [1:0]  i_size;
  logic [7:0]  i_dbgAddr;
  logic [31:0] o_memData, o_branchTarget, o_wbData, o_dbgData;
  logic [5:0]  o_rd_EX_MEM, o_rd_MEM_WB;
  logic        o_regWrite_EX_MEM, o_pcSrc, o_regWrite_MEM_WB, o_misaligned;

  memory_stage dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
    .i_aluResult(i_aluResult), .i_storeData(i_storeData), .i_cero(i_cero), .i_rd(i_rd),
    .i_memRead(i_memRead), .i_memWrite(i_memWrite), .i_memToReg(i_memToReg),
    .i_regWrite(i_regWrite), .i_branch(i_branch), .i_size(i_size), .i_unsigned(i_unsigned),
    .i_dbgAddr(i_dbgAddr),
    .o_memData(o_memData), .o_rd_EX_MEM(o_rd_EX_MEM), .o_regWrite_EX_MEM(o_regWrite_EX_MEM),
    .o_pcSrc(o_pcSrc), .o_branchTarget(o_branchTarget), .o_wbData(o_wbData),
    .o_rd_MEM_WB(o_rd_MEM_WB), .o_regWrite_MEM_WB(o_regWrite_MEM_WB),
    .o_misaligned(o_misaligned), .o_dbgData(o_dbgData)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] alu, sd;
    logic        cero;
    logic [5:0]  rd;
    logic        mr, mw, m2r, rw, br;
    logic [1:0]  sz;
    logic        uns, fl;
  } instr_t;

  typedef struct {
    logic [31:0] alu;
    logic [5:0]  rd;
    logic        rw_em, pcsrc;
    logic [31:0] wb;
    logic        rw_wb, mis;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem_b [1024];
  exp_t        q[$];
  exp_t        last_wb;
  exp_t        e0;
  instr_t      idle;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_word(input int idx);
    return {mem_b[4*idx+3], mem_b[4*idx+2], mem_b[4*idx+1], mem_b[4*idx]};
  endfunction

  // Little-endian byte memory; an instruction's effect is computed when it is issued
  task automatic model(input instr_t x, output exp_t e);
    logic [9:0]  a;
    logic        mr, mw, m2r, rw, br, fault;
    logic [31:0] ld;
    logic [15:0] h;
    a   = x.alu[9:0];
    mr  = x.mr  & ~x.fl;
    mw  = x.mw  & ~x.fl;
    m2r = x.m2r & ~x.fl;
    rw  = x.rw  & ~x.fl;
    br  = x.br  & ~x.fl;
    fault = (mr | mw) && (x.sz == 2'b10 || (x.sz == 2'b01 && a[0]) || (x.sz == 2'b11 && a[1:0] != 2'b00));
    ld = 32'h0;
    if (!fault) begin
      case (x.sz)
        2'b00: ld = x.uns ? {24'h0, mem_b[a]} : {{24{mem_b[a][7]}}, mem_b[a]};
        2'b01: begin
          h  = {mem_b[a + 10'd1], mem_b[a]};
          ld = x.uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        2'b11: ld = {mem_b[a + 10'd3], mem_b[a + 10'd2], mem_b[a + 10'd1], mem_b[a]};
        default: ld = 32'h0;
      endcase
    end
    if (mw && !fault) begin
      case (x.sz)
        2'b00: mem_b[a] = x.sd[7:0];
        2'b01: begin
          mem_b[a]         = x.sd[7:0];
          mem_b[a + 10'd1] = x.sd[15:8];
        end
        default: for (int k = 0; k < 4; k++) mem_b[a + 10'(k)] = x.sd[8*k +: 8];
      endcase
    end
    e.alu   = x.alu;
    e.rd    = x.rd;
    e.rw_em = rw;
    e.pcsrc = br & x.cero;
    e.wb    = m2r ? ld : x.alu;
    e.rw_wb = rw & ~fault;
    e.mis   = fault;
  endtask

  task automatic drive(input instr_t x);
    i_aluResult = x.alu;  i_storeData = x.sd;  i_cero = x.cero;  i_rd = x.rd;
    i_memRead = x.mr;  i_memWrite = x.mw;  i_memToReg = x.m2r;  i_regWrite = x.rw;
    i_branch = x.br;  i_size = x.sz;  i_unsigned = x.uns;  i_flush = x.fl;
  endtask

  task automatic check_exmem(input exp_t e);
    chk("exmem_alu", o_memData, e.alu);
    chk("exmem_rd", {26'h0, o_rd_EX_MEM}, {26'h0, e.rd});
    chk("exmem_rw", {31'h0, o_regWrite_EX_MEM}, {31'h0, e.rw_em});
    chk("pcsrc", {31'h0, o_pcSrc}, {31'h0, e.pcsrc});
    chk("btarget", o_branchTarget, e.alu);
  endtask

  task automatic check_memwb(input exp_t e);
    chk("wb_data", o_wbData, e.wb);
    chk("wb_rd", {26'h0, o_rd_MEM_WB}, {26'h0, e.rd});
    chk("wb_rw", {31'h0, o_regWrite_MEM_WB}, {31'h0, e.rw_wb});
    chk("wb_mis", {31'h0, o_misaligned}, {31'h0, e.mis});
  endtask

  task automatic issue(input instr_t x);
    exp_t e;
    drive(x);
    i_enable = 1'b1;
    model(x, e);
    q.push_back(e);
    @(posedge i_clk); #1;
    check_exmem(q[$]);
    last_wb = q.pop_front();
    check_memwb(last_wb);
  endtask

  task automatic stall_tick();
    instr_t junk;
    junk     = idle;
    junk.alu = $urandom();
    junk.rw  = 1'b1;
    drive(junk);
    i_enable = 1'b0;
    @(posedge i_clk); #1;
    check_exmem(q[$]);
    check_memwb(last_wb);
    i_enable = 1'b1;
  endtask

  task automatic do_reset(input int cycles);
    drive(idle);
    i_reset = 1'b1;
    repeat (cycles) @(posedge i_clk);
    #1;
    check_exmem(e0);
    check_memwb(e0);
    chk("rst_dbg", o_dbgData, 32'h0);
    i_reset = 1'b0;
    q.delete();
    q.push_back(e0);
    last_wb = e0;
  endtask

  function automatic instr_t mk(input logic [31:0] alu, input logic [31:0] sd, input logic [1:0] sz,
                                input logic ld, input logic st, input logic uns);
    instr_t x;
    x     = idle;
    x.alu = alu;  x.sd = sd;  x.sz = sz;  x.uns = uns;
    x.mr  = ld;   x.m2r = ld; x.rw = ld;  x.mw = st;
    x.rd  = ld ? 6'd9 : 6'd0;
    return x;
  endfunction

  function automatic instr_t rand_instr();
    instr_t      x;
    logic [31:0] r;
    int          k;
    r      = $urandom();
    k      = $urandom_range(0, 3);
    x      = idle;
    x.rd   = 6'($urandom_range(0, 63));
    x.cero = 1'($urandom_range(0, 1));
    x.sd   = $urandom();
    x.sz   = 2'($urandom_range(0, 3));
    x.uns  = 1'($urandom_range(0, 1));
    x.fl   = ($urandom_range(0, 9) == 0);
    x.alu  = {r[31:10], 10'h100 + 10'($urandom_range(0, 63))};
    case (k)
      0: begin x.alu = r; x.rw = 1'b1; end
      1: begin x.mr = 1'b1; x.m2r = 1'b1; x.rw = 1'b1; end
      2: x.mw = 1'b1;
      default: x.br = 1'b1;
    endcase
    return x;
  endfunction

  initial begin
    instr_t x;
    logic [31:0] r;
    e0   = '{alu: 32'h0, rd: 6'h0, rw_em: 1'b0, pcsrc: 1'b0, wb: 32'h0, rw_wb: 1'b0, mis: 1'b0};
    idle = '{alu: 32'h0, sd: 32'h0, cero: 1'b0, rd: 6'h0, mr: 1'b0, mw: 1'b0, m2r: 1'b0,
             rw: 1'b0, br: 1'b0, sz: 2'b11, uns: 1'b0, fl: 1'b0};
    for (int i = 0; i < 1024; i++) mem_b[i] = 8'h0;
    i_enable  = 1'b1;
    i_dbgAddr = 8'h0;
    do_reset(2);

    // word store then load
    issue(mk(32'h10, 32'h11223344, 2'b11, 1'b0, 1'b1, 1'b0));
    issue(mk(32'h10, 32'h0, 2'b11, 1'b1, 1'b0, 1'b0));
    issue(idle);
    chk("lw_0x10", o_wbData, 32'h11223344);
    chk("lw_rw", {31'h0, o_regWrite_MEM_WB}, 32'h1);

    // byte store, signed/unsigned byte loads, word readback
    issue(mk(32'h13, 32'h000000AB, 2'b00, 1'b0, 1'b1, 1'b0));
    issue(mk(32'h13, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0));
    issue(mk(32'h13, 32'h0, 2'b00, 1'b1, 1'b0, 1'b1));
    chk("lb_0x13", o_wbData, 32'hFFFFFFAB);
    issue(mk(32'h10, 32'h0, 2'b11, 1'b1, 1'b0, 1'b0));
    chk("lbu_0x13", o_wbData, 32'h000000AB);
    issue(idle);
    chk("lw_after_sb", o_wbData, 32'hAB223344);

    // misaligned half load and misaligned word store
    issue(mk(32'h11, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0));
    issue(mk(32'h12, 32'hDEADBEEF, 2'b11, 1'b0, 1'b1, 1'b0));
    chk("lh_mis", {31'h0, o_misaligned}, 32'h1);
    chk("lh_mis_rw", {31'h0, o_regWrite_MEM_WB}, 32'h0);
    issue(mk(32'h10, 32'h0, 2'b11, 1'b1, 1'b0, 1'b0));
    chk("sw_mis", {31'h0, o_misaligned}, 32'h1);
    issue(idle);
    chk("lw_unchanged", o_wbData, 32'hAB223344);

    // branch resolution, plain and flushed
    x = idle; x.br = 1'b1; x.cero = 1'b1; x.alu = 32'h40;
    issue(x);
    chk("br_pcsrc", {31'h0, o_pcSrc}, 32'h1);
    chk("br_target", o_branchTarget, 32'h40);
    x.fl = 1'b1;
    issue(x);
    chk("br_flush_pcsrc", {31'h0, o_pcSrc}, 32'h0);
    x = idle; x.br = 1'b1; x.cero = 1'b0; x.alu = 32'h44;
    issue(x);
    chk("br_nottaken", {31'h0, o_pcSrc}, 32'h0);

    // stall in the middle of a store
    issue(mk(32'h20, 32'hCAFEF00D, 2'b11, 1'b0, 1'b1, 1'b0));
    issue(idle);
    issue(idle);
    i_dbgAddr = 8'h08;
    issue(mk(32'h20, 32'h55AA55AA, 2'b11, 1'b0, 1'b1, 1'b0));
    chk("dbg_before", o_dbgData, 32'hCAFEF00D);
    for (int s = 0; s < 3; s++) begin
      stall_tick();
      chk("dbg_stall", o_dbgData, 32'hCAFEF00D);
    end
    issue(idle);
    issue(idle);
    chk("dbg_after", o_dbgData, 32'h55AA55AA);

    // randomized traffic over a 64-byte window, aliased through random upper address bits
    for (int w = 0; w < 16; w++) begin
      r = $urandom();
      issue(mk({r[31:10], 10'h100 + 10'(4*w)}, $urandom(), 2'b11, 1'b0, 1'b1, 1'b0));
    end
    for (int n = 0; n < 300; n++) begin
      issue(rand_instr());
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 2)) stall_tick();
      end
    end
    issue(idle);
    issue(idle);
    for (int w = 0; w < 16; w++) begin
      i_dbgAddr = 8'h40 + 8'(w);
      issue(idle);
      chk("dbg_window", o_dbgData, model_word(64 + w));
    end

    // reset mid-stream, memory retained
    for (int n = 0; n < 3; n++) begin
      x = idle; x.alu = $urandom(); x.rw = 1'b1; x.rd = 6'(n + 1);
      issue(x);
    end
    do_reset(1);
    issue(mk(32'h10, 32'h0, 2'b11, 1'b1, 1'b0, 1'b0));
    issue(idle);
    chk("lw_after_reset", o_wbData, 32'hAB223344);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
